mem_test_device_control: RTL and testbench

- FSM control unit paired with memTestDevice_datapath. It sequences the three-phase incrementing-pattern device test: fill, check-and-invert, then verify antipattern.
- Drives datapath enables and selects, and consumes the datapath's equal and offset-bound flags.
- Owns the memory request/acknowledge handshake and the address bus.
- Reports busy, done, pass and the first failing address to the host.

---
 rtl/mem_test_device_pkg.sv | 37 +++
 rtl/mem_test_ack_watchdog.sv | 37 +++
 rtl/mem_test_device_control.sv | 213 +++++++++++++++++++++
 tb/tb_mem_test_device_control.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_test_device_pkg.sv
// rtl/mem_test_device_pkg.sv - shared state encoding and codes for the memory test controller
package mem_test_device_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_INIT,
        ST_FILL_WR,
        ST_FILL_STEP,
        ST_FILL_TST,
        ST_CHK_INIT,
        ST_CHK_RD,
        ST_CHK_LOAD,
        ST_CHK_WR,
        ST_CHK_STEP,
        ST_CHK_TST,
        ST_VER_INIT,
        ST_VER_LOAD,
        ST_VER_RD,
        ST_VER_STEP,
        ST_VER_TST,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_CHECK   = 2'd1;
    localparam logic [1:0] FAIL_VERIFY  = 2'd2;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

    localparam logic SEL_PATTERN     = 1'b0;
    localparam logic SEL_ANTIPATTERN = 1'b1;

    function automatic logic is_access(input state_t s);
        return (s == ST_FILL_WR) || (s == ST_CHK_RD) || (s == ST_CHK_WR) || (s == ST_VER_RD);
    endfunction

endpackage

// File: rtl/mem_test_ack_watchdog.sv
// rtl/mem_test_ack_watchdog.sv - counts request cycles without ack and flags the terminal count
module mem_test_ack_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_ack,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;

    assign waiting = i_req & ~i_ack;

    always_comb begin
        cnt_d = '0;
        if (waiting) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fires during the TIMEOUT_CYCLES-th request cycle so the FSM leaves on that edge
    assign o_expired = waiting && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_test_device_control.sv
// rtl/mem_test_device_control.sv - fill/check/verify memory test sequencer; optional MEM_TEST_CTRL_TIMEOUT_EN ack watchdog
module mem_test_device_control
    import mem_test_device_pkg::*;
#(
    parameter int                              WIDTH_ADDRESS_MEMORY = 32,
    parameter int                              WORDS_QTD_MEMORY     = 8,
    parameter logic [WIDTH_ADDRESS_MEMORY-1:0] BASE_ADDRESS         = '0,
    parameter int                              TIMEOUT_CYCLES       = 256
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_equal_memory_pattern,
    input  logic                            i_less_offset_nwords,
    input  logic                            i_mem_ack,
    output logic                            o_ena_reg_pattern,
    output logic                            o_ena_reg_antipattern,
    output logic                            o_ena_reg_offset,
    output logic                            o_rst_reg,
    output logic                            o_sel_mux_memory_data_read,
    output logic                            o_sel_mux_memory_data_write,
    output logic                            o_mem_req,
    output logic                            o_mem_we,
    output logic [WIDTH_ADDRESS_MEMORY-1:0] o_mem_addr,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_pass,
    output logic [WIDTH_ADDRESS_MEMORY-1:0] o_fail_addr,
    output logic [1:0]                      o_fail_phase
);

    localparam int OFFW = $clog2(WORDS_QTD_MEMORY + 1);

    state_t                          state_q, state_d;
    logic [OFFW-1:0]                 offset_q, offset_d;
    logic                            ena_pattern_q, ena_pattern_d;
    logic                            ena_antipattern_q, ena_antipattern_d;
    logic                            ena_offset_q, ena_offset_d;
    logic                            rst_reg_q, rst_reg_d;
    logic                            sel_read_q, sel_read_d;
    logic                            sel_write_q, sel_write_d;
    logic                            mem_req_q, mem_req_d;
    logic                            mem_we_q, mem_we_d;
    logic [WIDTH_ADDRESS_MEMORY-1:0] mem_addr_q, mem_addr_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            pass_q, pass_d;
    logic [WIDTH_ADDRESS_MEMORY-1:0] fail_addr_q, fail_addr_d;
    logic [1:0]                      fail_phase_q, fail_phase_d;
    logic                            ack;
    logic                            wdg_expired;

    assign ack = i_mem_ack & mem_req_q;

`ifdef MEM_TEST_CTRL_TIMEOUT_EN
    mem_test_ack_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ack_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (mem_req_q),
        .i_ack    (i_mem_ack),
        .o_expired(wdg_expired)
    );
`else
    assign wdg_expired = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        fail_addr_d  = fail_addr_q;
        fail_phase_d = fail_phase_q;

        // Offset moves on the same edges as the datapath offset accumulator
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: if (i_start) state_d = ST_INIT;
            ST_INIT: begin
                offset_d = '0;
                state_d  = ST_FILL_WR;
            end
            ST_FILL_WR:   if (ack) state_d = ST_FILL_STEP;
            ST_FILL_STEP: begin
                offset_d = offset_q + OFFW'(1);
                state_d  = ST_FILL_TST;
            end
            ST_FILL_TST:  state_d = i_less_offset_nwords ? ST_FILL_WR : ST_CHK_INIT;
            ST_CHK_INIT: begin
                offset_d = '0;
                state_d  = ST_CHK_RD;
            end
            ST_CHK_RD: begin
                if (ack) begin
                    if (i_equal_memory_pattern) begin
                        state_d = ST_CHK_LOAD;
                    end else begin
                        state_d      = ST_FAIL;
                        fail_addr_d  = mem_addr_q;
                        fail_phase_d = FAIL_CHECK;
                    end
                end
            end
            ST_CHK_LOAD:  state_d = ST_CHK_WR;
            ST_CHK_WR:    if (ack) state_d = ST_CHK_STEP;
            ST_CHK_STEP: begin
                offset_d = offset_q + OFFW'(1);
                state_d  = ST_CHK_TST;
            end
            ST_CHK_TST:   state_d = i_less_offset_nwords ? ST_CHK_RD : ST_VER_INIT;
            ST_VER_INIT: begin
                offset_d = '0;
                state_d  = ST_VER_LOAD;
            end
            ST_VER_LOAD:  state_d = ST_VER_RD;
            ST_VER_RD: begin
                if (ack) begin
                    if (i_equal_memory_pattern) begin
                        state_d = ST_VER_STEP;
                    end else begin
                        state_d      = ST_FAIL;
                        fail_addr_d  = mem_addr_q;
                        fail_phase_d = FAIL_VERIFY;
                    end
                end
            end
            ST_VER_STEP: begin
                offset_d = offset_q + OFFW'(1);
                state_d  = ST_VER_TST;
            end
            ST_VER_TST:   state_d = i_less_offset_nwords ? ST_VER_LOAD : ST_DONE;
            default:      state_d = ST_IDLE;
        endcase

        if (wdg_expired) begin
            state_d      = ST_FAIL;
            fail_addr_d  = mem_addr_q;
            fail_phase_d = FAIL_TIMEOUT;
        end

        if (state_d == ST_INIT) begin
            fail_addr_d  = '0;
            fail_phase_d = FAIL_NONE;
        end

        // Outputs are decoded from the next state so they register alongside it
        ena_pattern_d     = (state_d == ST_FILL_STEP) || (state_d == ST_CHK_STEP) || (state_d == ST_VER_STEP);
        ena_offset_d      = ena_pattern_d;
        ena_antipattern_d = (state_d == ST_CHK_LOAD) || (state_d == ST_VER_LOAD);
        rst_reg_d         = (state_d == ST_INIT) || (state_d == ST_CHK_INIT) || (state_d == ST_VER_INIT);
        sel_read_d        = (state_d == ST_VER_RD) ? SEL_ANTIPATTERN : SEL_PATTERN;
        sel_write_d       = (state_d == ST_CHK_WR) ? SEL_ANTIPATTERN : SEL_PATTERN;
        mem_req_d         = is_access(state_d);
        mem_we_d          = (state_d == ST_FILL_WR) || (state_d == ST_CHK_WR);
        mem_addr_d        = BASE_ADDRESS + WIDTH_ADDRESS_MEMORY'(offset_d);
        done_d            = (state_d == ST_DONE) || (state_d == ST_FAIL);
        pass_d            = (state_d == ST_DONE);
        busy_d            = !((state_d == ST_IDLE) || done_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q           <= ST_IDLE;
            offset_q          <= '0;
            ena_pattern_q     <= 1'b0;
            ena_antipattern_q <= 1'b0;
            ena_offset_q      <= 1'b0;
            rst_reg_q         <= 1'b0;
            sel_read_q        <= 1'b0;
            sel_write_q       <= 1'b0;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_addr_q        <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            fail_addr_q       <= '0;
            fail_phase_q      <= FAIL_NONE;
        end else begin
            state_q           <= state_d;
            offset_q          <= offset_d;
            ena_pattern_q     <= ena_pattern_d;
            ena_antipattern_q <= ena_antipattern_d;
            ena_offset_q      <= ena_offset_d;
            rst_reg_q         <= rst_reg_d;
            sel_read_q        <= sel_read_d;
            sel_write_q       <= sel_write_d;
            mem_req_q         <= mem_req_d;
            mem_we_q          <= mem_we_d;
            mem_addr_q        <= mem_addr_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            fail_addr_q       <= fail_addr_d;
            fail_phase_q      <= fail_phase_d;
        end
    end

    assign o_ena_reg_pattern           = ena_pattern_q;
    assign o_ena_reg_antipattern       = ena_antipattern_q;
    assign o_ena_reg_offset            = ena_offset_q;
    assign o_rst_reg                   = rst_reg_q;
    assign o_sel_mux_memory_data_read  = sel_read_q;
    assign o_sel_mux_memory_data_write = sel_write_q;
    assign o_mem_req                   = mem_req_q;
    assign o_mem_we                    = mem_we_q;
    assign o_mem_addr                  = mem_addr_q;
    assign o_busy                      = busy_q;
    assign o_done                      = done_q;
    assign o_pass                      = pass_q;
    assign o_fail_addr                 = fail_addr_q;
    assign o_fail_phase                = fail_phase_q;

endmodule

// File: tb/tb_mem_test_device_control.sv
// tb/tb_mem_test_device_control.sv - scoreboard bench with datapath and memory models around the controller
module tb_mem_test_device_control;

    localparam int          AW   = 32;
    localparam int          NW   = 8;
    localparam logic [31:0] BASE = 32'h100;
    localparam int          TMO  = 16;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_equal, i_less, i_mem_ack;
    logic          o_ena_pat, o_ena_anti, o_ena_off, o_rst_reg, o_sel_rd, o_sel_wr;
    logic          o_mem_req, o_mem_we, o_busy, o_done, o_pass;
    logic [AW-1:0] o_mem_addr, o_fail_addr;
    logic [1:0]    o_fail_phase;

    always #5 clk = ~clk;

    mem_test_device_control #(
        .WIDTH_ADDRESS_MEMORY(AW),
        .WORDS_QTD_MEMORY    (NW),
        .BASE_ADDRESS        (BASE),
        .TIMEOUT_CYCLES      (TMO)
    ) dut (
        .i_clk                      (clk),
        .i_rst                      (i_rst),
        .i_start                    (i_start),
        .i_equal_memory_pattern     (i_equal),
        .i_less_offset_nwords       (i_less),
        .i_mem_ack                  (i_mem_ack),
        .o_ena_reg_pattern          (o_ena_pat),
        .o_ena_reg_antipattern      (o_ena_anti),
        .o_ena_reg_offset           (o_ena_off),
        .o_rst_reg                  (o_rst_reg),
        .o_sel_mux_memory_data_read (o_sel_rd),
        .o_sel_mux_memory_data_write(o_sel_wr),
        .o_mem_req                  (o_mem_req),
        .o_mem_we                   (o_mem_we),
        .o_mem_addr                 (o_mem_addr),
        .o_busy                     (o_busy),
        .o_done                     (o_done),
        .o_pass                     (o_pass),
        .o_fail_addr                (o_fail_addr),
        .o_fail_phase               (o_fail_phase)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {logic [31:0] addr; logic we;} acc_t;
    typedef struct packed {logic pass; logic [1:0] phase; logic [31:0] addr;} res_t;
    acc_t exp_q[$];
    res_t res_q[$];

    // Reference datapath: pattern starts at 1, antipattern is ~pattern on load
    logic [7:0] dp_pat  = 8'd1;
    logic [7:0] dp_anti = 8'd0;
    logic [3:0] dp_off  = 4'd0;
    logic [7:0] rdata   = 8'd0;

    always @(posedge clk) begin
        if (o_rst_reg) begin
            dp_pat <= 8'd1;
            dp_off <= 4'd0;
        end else begin
            if (o_ena_pat) dp_pat <= dp_pat + 8'd1;
            if (o_ena_off) dp_off <= dp_off + 4'd1;
        end
        if (o_ena_anti) dp_anti <= ~dp_pat;
    end

    assign i_less  = (dp_off < NW);
    assign i_equal = (rdata == (o_sel_rd ? dp_anti : dp_pat));

    logic [7:0] mem [0:NW-1];
    bit fault_alias = 0, fault_stuck = 0, rand_lat = 0, no_ack = 0, stalled = 0;
    int stall_at = -1, acc_idx = 0, req_cycles = 0;

    function automatic int idx_of(input logic [31:0] a);
        int i;
        i = int'(a - BASE) & (NW - 1);
        if (fault_alias && i == 5) i = 1;
        return i;
    endfunction

    initial begin
        bit         in_acc;
        int         lat;
        int         k;
        acc_t       cur, e;
        logic [7:0] wd;
        in_acc    = 0;
        lat       = 0;
        i_mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_mem_ack = 1'b0;
            if (i_rst || !o_mem_req) begin
                in_acc = 0;
            end else begin
                req_cycles++;
                if (!in_acc) begin
                    in_acc   = 1;
                    cur.addr = o_mem_addr;
                    cur.we   = o_mem_we;
                    lat      = rand_lat ? int'($urandom_range(1, 5)) : 1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_access", o_mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("acc_addr", o_mem_addr, e.addr);
                        check("acc_we", {31'd0, o_mem_we}, {31'd0, e.we});
                    end
                    if (acc_idx == stall_at) stalled = 1;
                    acc_idx++;
                end else begin
                    check("hold_addr", o_mem_addr, cur.addr);
                    check("hold_we", {31'd0, o_mem_we}, {31'd0, cur.we});
                end
                if (!no_ack && !stalled) begin
                    lat--;
                    if (lat == 0) begin
                        k = idx_of(cur.addr);
                        if (cur.we) begin
                            wd = o_sel_wr ? dp_anti : dp_pat;
                            if (fault_stuck && k == 3) wd[0] = 1'b0;
                            mem[k] = wd;
                        end else begin
                            rdata = mem[k];
                        end
                        i_mem_ack = 1'b1;
                        in_acc    = 0;
                    end
                end
            end
        end
    end

    task automatic push_seq(input int stop_phase, input int stop_off);
        acc_t a;
        for (int i = 0; i < NW; i++) begin
            a.addr = BASE + i; a.we = 1'b1; exp_q.push_back(a);
        end
        for (int i = 0; i < NW; i++) begin
            a.addr = BASE + i; a.we = 1'b0; exp_q.push_back(a);
            if (stop_phase == 1 && i == stop_off) return;
            a.we = 1'b1; exp_q.push_back(a);
        end
        for (int i = 0; i < NW; i++) begin
            a.addr = BASE + i; a.we = 1'b0; exp_q.push_back(a);
            if (stop_phase == 2 && i == stop_off) return;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NW; i++) mem[i] = 8'h00;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!o_done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!o_done) check({tag, "_wait_done"}, {31'd0, o_done}, 32'd1);
    endtask

    task automatic check_result(input string tag);
        res_t r;
        r = res_q.pop_front();
        check({tag, "_done"}, {31'd0, o_done}, 32'd1);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_pass"}, {31'd0, o_pass}, {31'd0, r.pass});
        check({tag, "_phase"}, {30'd0, o_fail_phase}, {30'd0, r.phase});
        check({tag, "_fail_addr"}, o_fail_addr, r.addr);
        check({tag, "_leftover_acc"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int   a0;
        int   n;
        res_t r;
        i_rst   = 1'b1;
        i_start = 1'b0;
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, o_mem_req}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_pass", {31'd0, o_pass}, 32'd0);
        check("rst_phase", {30'd0, o_fail_phase}, 32'd0);
        check("rst_fail_addr", o_fail_addr, 32'd0);
        i_rst = 1'b0;

        // Clean pass, single-cycle ack
        push_seq(0, 0);
        r = '{pass: 1'b1, phase: 2'd0, addr: 32'd0}; res_q.push_back(r);
        a0 = acc_idx;
        pulse_start();
        check("start_busy", {31'd0, o_busy}, 32'd1);
        wait_done("pass1", 1000);
        check_result("pass1");
        check("pass1_acc_count", acc_idx - a0, 32'd32);

        // Stuck-at-0 on bit 0 of word 3 only shows in the antipattern verify
        clear_mem(); fault_stuck = 1;
        push_seq(2, 3);
        r = '{pass: 1'b0, phase: 2'd2, addr: BASE + 3}; res_q.push_back(r);
        pulse_start();
        wait_done("stuck", 1000);
        check_result("stuck");
        fault_stuck = 0;

        // Word 5 aliases onto word 1
        clear_mem(); fault_alias = 1;
        push_seq(1, 1);
        r = '{pass: 1'b0, phase: 2'd1, addr: BASE + 1}; res_q.push_back(r);
        pulse_start();
        check("restart_clears_done", {31'd0, o_done}, 32'd0);
        check("restart_clears_phase", {30'd0, o_fail_phase}, 32'd0);
        wait_done("alias", 1000);
        check_result("alias");
        fault_alias = 0;

        // Random ack latency; a start pulse mid-run must not disturb the sequence
        clear_mem(); rand_lat = 1;
        push_seq(0, 0);
        r = '{pass: 1'b1, phase: 2'd0, addr: 32'd0}; res_q.push_back(r);
        pulse_start();
        check("restart_clears_fail_addr", o_fail_addr, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        pulse_start();
        wait_done("randlat", 3000);
        check_result("randlat");
        rand_lat = 0;

        // Reset while the check-phase write to word 4 is pending
        clear_mem();
        push_seq(0, 0);
        stall_at = acc_idx + 17;
        pulse_start();
        n = 0;
        while (!stalled && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_reached", {31'd0, stalled}, 32'd1);
        check("stall_addr", o_mem_addr, BASE + 4);
        check("stall_we", {31'd0, o_mem_we}, 32'd1);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_req", {31'd0, o_mem_req}, 32'd0);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_strobes", {28'd0, o_ena_pat, o_ena_anti, o_ena_off, o_rst_reg}, 32'd0);
        check("midrst_done", {31'd0, o_done}, 32'd0);
        i_rst = 1'b0;
        exp_q.delete();
        stalled  = 0;
        stall_at = -1;
        clear_mem();
        push_seq(0, 0);
        r = '{pass: 1'b1, phase: 2'd0, addr: 32'd0}; res_q.push_back(r);
        pulse_start();
        wait_done("postrst", 1000);
        check_result("postrst");

        // Memory that never acknowledges
        clear_mem(); no_ack = 1;
        exp_q.push_back('{addr: BASE, we: 1'b1});
`ifdef MEM_TEST_CTRL_TIMEOUT_EN
        r = '{pass: 1'b0, phase: 2'd3, addr: BASE}; res_q.push_back(r);
        pulse_start();
        req_cycles = 0;
        wait_done("timeout", 200);
        check_result("timeout");
        check("timeout_req_cycles", req_cycles, TMO);
        check("timeout_req_dropped", {31'd0, o_mem_req}, 32'd0);
`else
        pulse_start();
        repeat (60) @(posedge clk);
        #1;
        check("noack_req_held", {31'd0, o_mem_req}, 32'd1);
        check("noack_busy", {31'd0, o_busy}, 32'd1);
        check("noack_done", {31'd0, o_done}, 32'd0);
        check("noack_addr", o_mem_addr, BASE);
        check("noack_phase", {30'd0, o_fail_phase}, 32'd0);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        check("noack_leftover_acc", exp_q.size(), 32'd0);
`endif
        no_ack = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
